// File: rtl/aes_pkg.sv
// Shared AES definitions: block sizes, round-unit FSM encoding and the
// GF(2^4)^2 composite-field arithmetic used by the S-box implementations.
package aes_pkg;

  localparam int unsigned AES_BLOCK_BITS  = 128;
  localparam int unsigned AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // x^2 + x + lambda is irreducible over GF(2^4) = GF(2)[x]/(x^4 + x + 1)
  localparam logic [3:0] GF4_LAMBDA = 4'hC;

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] c;
    c[0] = a[0] & b[0];
    c[1] = (a[0] & b[1]) ^ (a[1] & b[0]);
    c[2] = (a[0] & b[2]) ^ (a[1] & b[1]) ^ (a[2] & b[0]);
    c[3] = (a[0] & b[3]) ^ (a[1] & b[2]) ^ (a[2] & b[1]) ^ (a[3] & b[0]);
    c[4] = (a[1] & b[3]) ^ (a[2] & b[2]) ^ (a[3] & b[1]);
    c[5] = (a[2] & b[3]) ^ (a[3] & b[2]);
    c[6] = a[3] & b[3];
    return {c[3] ^ c[6], c[2] ^ c[5] ^ c[6], c[1] ^ c[4] ^ c[5], c[0] ^ c[4]};
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return gf4_mul(a, a);
  endfunction

  // a^-1 = a^14 = a^2 * a^4 * a^8; maps 0 to 0
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a2, a4), a8);
  endfunction

  function automatic logic [7:0] cf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf4_mul(a[7:4], b[7:4]);
    return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
            gf4_mul(hh, GF4_LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
  endfunction

  // Composite-field root of the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] cf_root();
    logic [7:0] b, b2, b3, b4, b8, r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int c = 16; c < 256; c++) begin
      b  = 8'(c);
      b2 = cf_mul(b, b);
      b3 = cf_mul(b2, b);
      b4 = cf_mul(b2, b2);
      b8 = cf_mul(b4, b4);
      if (!found && ((b8 ^ b4 ^ b3 ^ b ^ 8'h01) == 8'h00)) begin
        r     = b;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] cf_basis(input logic [7:0] root);
    logic [63:0] m;
    logic [7:0]  p;
    m = '0;
    p = 8'h01;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = p;
      p = cf_mul(p, root);
    end
    return m;
  endfunction

  function automatic logic [7:0] lin_map(input logic [7:0] a, input logic [63:0] m);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) r = r ^ m[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] cf_basis_inv(input logic [63:0] m);
    logic [63:0] r;
    logic [7:0]  v;
    r = '0;
    for (int c = 0; c < 256; c++) begin
      v = lin_map(8'(c), m);
      for (int j = 0; j < 8; j++) begin
        if (v == 8'(1 << j)) r[8*j +: 8] = 8'(c);
      end
    end
    return r;
  endfunction

  // Basis-change matrices, one column byte per input bit, fixed at elaboration
  localparam logic [7:0]  CF_ROOT   = cf_root();
  localparam logic [63:0] TO_CF     = cf_basis(CF_ROOT);
  localparam logic [63:0] FROM_CF   = cf_basis_inv(TO_CF);

  function automatic logic [7:0] to_composite(input logic [7:0] a);
    return lin_map(a, TO_CF);
  endfunction

  function automatic logic [7:0] from_composite(input logic [7:0] a);
    return lin_map(a, FROM_CF);
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[1] ^ s[4] ^ s[6], s[0] ^ s[3] ^ s[5], s[7] ^ s[2] ^ s[4],
            s[6] ^ s[1] ^ s[3], s[5] ^ s[0] ^ s[2], s[4] ^ s[7] ^ s[1],
            s[3] ^ s[6] ^ s[0], s[2] ^ s[5] ^ s[7]} ^ 8'h05;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: inverse affine, then multiplicative
// inverse computed in GF(2^4)^2.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o_c
);

  logic [7:0] aff_c;
  logic [7:0] cf_c;
  logic [3:0] hi_c;
  logic [3:0] lo_c;
  logic [3:0] d_c;
  logic [3:0] dinv_c;

  // (h x + l)^-1 = h d^-1 x + (h + l) d^-1, d = h^2 lambda + h l + l^2
  always_comb begin
    aff_c    = inv_affine(byte_i);
    cf_c     = to_composite(aff_c);
    hi_c     = cf_c[7:4];
    lo_c     = cf_c[3:0];
    d_c      = gf4_mul(gf4_sq(hi_c), GF4_LAMBDA) ^ gf4_mul(hi_c, lo_c) ^ gf4_sq(lo_c);
    dinv_c   = gf4_inv(d_c);
    byte_o_c = from_composite({gf4_mul(hi_c, dinv_c), gf4_mul(hi_c ^ lo_c, dinv_c)});
  end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes: loads a 128-bit state, substitutes BYTES_PER_CYCLE
// bytes per cycle in place, then holds the result until it is taken.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned NCHUNK     = AES_BLOCK_BYTES / BYTES_PER_CYCLE;
  localparam int unsigned CW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CHUNK_BITS = 8 * BYTES_PER_CYCLE;

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
    $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  aes_state_e                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [AES_BLOCK_BITS-1:0] data_q, data_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;

  logic [6:0]                base_c;
  logic [CHUNK_BITS-1:0]     chunk_c;
  logic [CHUNK_BITS-1:0]     sub_c;

  always_comb begin
    base_c  = 7'(CHUNK_BITS * 32'(cnt_q));
    chunk_c = data_q[base_c +: CHUNK_BITS];
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .byte_i   (chunk_c[8*g +: 8]),
      .byte_o_c (sub_c[8*g +: 8])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Handshake flags are registered from the next state so they line up with it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        data_d[base_c +: CHUNK_BITS] = sub_c;
        if (cnt_q == CW'(NCHUNK - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench for inv_sub_bytes_seq (BPC=4), with BPC=1 and BPC=16
// instances checked for latency on the reference block.
module tb_inv_sub_bytes_seq;

  localparam int unsigned BPC  = 4;
  localparam int unsigned NCH  = 16 / BPC;
  localparam logic [127:0] V1  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] E1  = 128'hFBD7F3819EA340BF38A53630D56A0952;

  logic [7:0] inv_tab [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;

  logic         xrst = 1'b1;
  logic         xvalid = 1'b0;
  logic         xready = 1'b1;
  logic [127:0] xdata = '0;
  logic         o1_ready, o1_valid, o1_busy, o16_ready, o16_valid, o16_busy;
  logic [127:0] o1_data, o16_data;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           accept_cyc = 0;
  logic [127:0] exp_q [$];
  bit           stream_done = 1'b0;
  bit           x_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(xrst), .in_valid(xvalid), .in_ready(o1_ready), .in_data(xdata),
    .out_valid(o1_valid), .out_ready(xready), .out_data(o1_data), .busy(o1_busy)
  );
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .reset(xrst), .in_valid(xvalid), .in_ready(o16_ready), .in_data(xdata),
    .out_valid(o16_valid), .out_ready(xready), .out_data(o16_data), .busy(o16_busy)
  );

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[d[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // Called at posedge+1; waits for in_ready, records the expected result at accept
  task automatic send(input logic [127:0] d, input logic [127:0] exp);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) fail_now("send_accept");
    else exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || busy) fail_now("drain");
  endtask

  // Monitor: handshake invariants, accept-to-valid latency, in-order scoreboard
  initial begin
    logic prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy) check("in_ready_low_when_busy", 128'(in_ready), 128'(0));
        if (out_valid) check("busy_in_done", 128'(busy), 128'(1));
        if (in_valid && in_ready) accept_cyc = cyc + 1;
        if (out_valid && !prev_ov) check("latency", 128'(cyc - accept_cyc), 128'(NCH));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got %h want none", out_data);
          end else begin
            check("out_data", out_data, exp_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  // BPC=1 and BPC=16 instances on the reference block
  initial begin
    int lat1 = 0;
    int lat16 = 0;
    repeat (3) @(posedge clk);
    #1 xrst = 1'b0;
    @(posedge clk); #1;
    check("x_ready_bpc1", 128'(o1_ready), 128'(1));
    check("x_ready_bpc16", 128'(o16_ready), 128'(1));
    xdata  = V1;
    xvalid = 1'b1;
    @(posedge clk); #1;
    xvalid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (o1_valid && lat1 == 0) begin
        lat1 = c;
        check("x_data_bpc1", o1_data, E1);
        check("x_busy_bpc1", 128'(o1_busy), 128'(1));
      end
      if (o16_valid && lat16 == 0) begin
        lat16 = c;
        check("x_data_bpc16", o16_data, E1);
        check("x_busy_bpc16", 128'(o16_busy), 128'(1));
      end
    end
    check("x_latency_bpc1", 128'(lat1), 128'(16));
    check("x_latency_bpc16", 128'(lat16), 128'(1));
    x_done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 128'(in_ready), 128'(1));

    out_ready = 1'b1;
    send(V1, E1);
    drain();
    send({16{8'h63}}, {16{8'h00}});
    send({16{8'h16}}, {16{8'hFF}});
    send({16{8'hED}}, {16{8'h53}});
    drain();

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * k + i);
      send(d, model(d));
    end
    drain();

    // Back-pressure: DONE held with out_ready low, input activity ignored
    out_ready = 1'b0;
    send(V1, E1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) fail_now("bp_valid");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_data", out_data, E1);
      check("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset during the second BUSY cycle discards the partial block
    in_data  = V1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_out_data", out_data, 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready_after", 128'(in_ready), 128'(1));
    send({16{8'hED}}, {16{8'h53}});
    drain();

    // Random stream with random gaps and back-pressure
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          d = {$urandom(), $urandom(), $urandom(), $urandom()};
          send(d, model(d));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    n = 0;
    while (!x_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!x_done) fail_now("x_done");
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
